// File: rtl/dds_cfg_arbiter.sv
// Two-port arbiter for the chirp DDS configuration channel: serialises
// requester parameter sets onto the DDS REQ/ACK crossing with a timeout.
module dds_cfg_arbiter #(
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [47:0] FREQ0,
  input  logic [47:0] FREQ1,
  input  logic [47:0] STEP0,
  input  logic [47:0] STEP1,
  input  logic [31:0] RATE0,
  input  logic [31:0] RATE1,
  input  logic        START0,
  input  logic        START1,
  output logic        ACK0,
  output logic        ACK1,
  output logic        ERR,
  output logic        ERR_ID,
  output logic [47:0] DDS_freq,
  output logic [47:0] DDS_delta_freq,
  output logic [31:0] DDS_delta_rate,
  output logic        REQ,
  input  logic        ACK,
  output logic        DDS_start
);

  localparam int unsigned CW = (TIMEOUT < 1)    ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_AH,
    WAIT_AL,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic          ack_meta_q, ack_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          grant_q, grant_d;
  logic          owner_q, owner_d;
  logic          req_q, req_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic          err_id_q, err_id_d;
  logic          start_q, start_d;
  logic [47:0]   freq_q, freq_d;
  logic [47:0]   step_q, step_d;
  logic [31:0]   rate_q, rate_d;

  logic          pick1;
  logic          grant_req;
  logic          cnt_hit;
  logic [CW-1:0] cnt_inc;

  // Port 1 only wins a contested grant once port 0 has had STARVE_MAX turns.
  assign pick1     = REQ1 && (!REQ0 || (starve_q == SW'(STARVE_MAX)));
  assign grant_req = grant_q ? REQ1 : REQ0;
  assign cnt_inc   = cnt_q + CW'(1);
  assign cnt_hit   = (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = REQ1 ? starve_q : '0;
    grant_d  = grant_q;
    owner_d  = owner_q;
    req_d    = req_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    err_d    = err_q;
    err_id_d = err_id_q;
    start_d  = owner_q ? START1 : START0;
    freq_d   = freq_q;
    step_d   = step_q;
    rate_d   = rate_q;

    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          grant_d = pick1;
          freq_d  = pick1 ? FREQ1 : FREQ0;
          step_d  = pick1 ? STEP1 : STEP0;
          rate_d  = pick1 ? RATE1 : RATE0;
          state_d = SETUP;
          if (pick1) begin
            starve_d = '0;
          end else if (REQ1 && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end

      SETUP: begin
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_AH;
      end

      WAIT_AH: begin
        if (ack_s_q) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_AL;
        end else if (cnt_hit) begin
          req_d    = 1'b0;
          err_d    = 1'b1;
          err_id_d = grant_q;
          ack0_d   = !grant_q;
          ack1_d   = grant_q;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_AL: begin
        if (!ack_s_q) begin
          owner_d = grant_q;
          err_d   = 1'b0;
          ack0_d  = !grant_q;
          ack1_d  = grant_q;
          state_d = RESP;
        end else if (cnt_hit) begin
          req_d    = 1'b0;
          err_d    = 1'b1;
          err_id_d = grant_q;
          ack0_d   = !grant_q;
          ack1_d   = grant_q;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RESP: begin
        if (!grant_req) begin
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      cnt_q      <= '0;
      starve_q   <= '0;
      grant_q    <= 1'b0;
      owner_q    <= 1'b0;
      req_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      err_id_q   <= 1'b0;
      start_q    <= 1'b0;
      freq_q     <= '0;
      step_q     <= '0;
      rate_q     <= '0;
    end else begin
      state_q    <= state_d;
      ack_meta_q <= ACK;
      ack_s_q    <= ack_meta_q;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
      start_q    <= start_d;
      freq_q     <= freq_d;
      step_q     <= step_d;
      rate_q     <= rate_d;
    end
  end

  assign ACK0           = ack0_q;
  assign ACK1           = ack1_q;
  assign ERR            = err_q;
  assign ERR_ID         = err_id_q;
  assign DDS_freq       = freq_q;
  assign DDS_delta_freq = step_q;
  assign DDS_delta_rate = rate_q;
  assign REQ            = req_q;
  assign DDS_start      = start_q;

endmodule

// File: doc/dds_cfg_arbiter.md
# dds_cfg_arbiter

Shares the single chirp DDS configuration channel between two requesters in the 48 MHz domain: port 0 is the pulse synchronizer, port 1 is the MCU/calibration path. Each requester delivers a frequency/step/rate set over a four-phase REQ/ACK handshake. The arbiter serialises these sets onto the DDS REQ/ACK crossing to the 96 MHz domain, and applies a timeout to that crossing. It also routes the DDS start strobe from the port that last configured the DDS.

## Interface
Parameters:
- TIMEOUT, 1023: CLK cycles allowed per downstream ACK edge before abort; counter width is $clog2(TIMEOUT+1).
- STARVE_MAX, 4: consecutive port-0 grants allowed while port 1 waits.

Ports:
- CLK  in  1  48 MHz clock.
- rst_n  in  1  asynchronous, active-low reset.
- REQ0 / REQ1  in  1  requester four-phase request; data must be stable while high.
- FREQ0 / FREQ1  in  48  DDS frequency word.
- STEP0 / STEP1  in  48  DDS frequency step.
- RATE0 / RATE1  in  32  DDS step rate.
- START0 / START1  in  1  requester DDS start level.
- ACK0 / ACK1  out  1  requester four-phase acknowledge.
- ERR  out  1  sticky timeout flag; cleared by the next successful transfer.
- ERR_ID  out  1  port whose transfer timed out.
- DDS_freq  out  48  latched frequency to the DDS.
- DDS_delta_freq  out  48  latched step to the DDS.
- DDS_delta_rate  out  32  latched rate to the DDS.
- REQ  out  1  request to the DDS (crosses to 96 MHz).
- ACK  in  1  DDS acknowledge; asynchronous, double-flop synchronised internally to ack_s.
- DDS_start  out  1  registered START of the current owner.

## Operation
- FSM states: IDLE, SETUP, WAIT_AH, WAIT_AL, RESP.
- IDLE: grant one requester.
  - Port 0 has priority.
  - Port 1 wins if REQ1=1 and the starvation counter equals STARVE_MAX.
  - The starvation counter increments on each port-0 grant while REQ1=1, and clears on any port-1 grant or when REQ1=0.
  - On grant: latch FREQ/STEP/RATE of the winner into the DDS_* registers, record the grant port, go to SETUP.
- SETUP: one cycle with data stable, then REQ←1, clear the timeout counter, go to WAIT_AH.
- WAIT_AH: on ack_s=1, REQ←0, clear the counter, go to WAIT_AL.
- WAIT_AL: on ack_s=0, the transfer succeeds.
  - owner←grant port, ERR←0.
  - Go to RESP.
- Timeout (WAIT_AH or WAIT_AL, counter reaches TIMEOUT):
  - REQ←0, ERR←1, ERR_ID←grant port.
  - owner is unchanged.
  - Go to RESP.
- RESP: ACKx of the grant port ←1. When REQx=0, ACKx←0 and go to IDLE.
- DDS_start is registered each cycle from START_owner.
- DDS_* outputs change only on a grant. They hold their last value otherwise, including after a timeout.
- Reset:
  - State IDLE; REQ, ACK0, ACK1, ERR, ERR_ID, DDS_start all 0.
  - DDS_* all 0; owner 0; counters 0; sync flops 0.
  - Reset mid-transfer abandons it immediately. The DDS side sees REQ drop.

## Timing
- REQx rises and is sampled at edge N in IDLE:
  - grant/latch at edge N;
  - REQ=1 after edge N+1.
- ACK rises before edge k: ack_s=1 after edge k+1, REQ=0 after edge k+2.
- ACK falls before edge m: ACKx=1 after edge m+2.
- REQx dropped before edge r: ACKx=0 after edge r. IDLE can grant again at edge r+1, so there is one dead cycle minimum.
- Minimum handshake with an instant DDS: 7 cycles from REQx to ACKx.
- Simultaneous REQ0 and REQ1: port 0 is granted unless starvation triggers. The loser's REQ stays high and it is granted in the next IDLE.
- A requester dropping REQx before ACKx has no effect on an in-flight transfer. Dropping REQx is a protocol violation and is not checked.
- An ACK glitch shorter than one CLK may be missed. The DDS must hold ACK until REQ falls.
- The timeout counter saturates and is not free-running. Timeout fires after exactly TIMEOUT cycles in the state.

## Test plan
- Single port-0 transfer, FREQ0=48'h1000000000, STEP0=48'h100000, RATE0=32'h100, DDS ACK 3 cycles after REQ -> DDS_* equal the inputs before REQ rises; ACK0 pulses high until REQ0 falls; ERR=0; ACK1 stays 0.
- REQ0 and REQ1 asserted on the same edge -> port 0 is served first; port 1 is served next with its own data; DDS_start follows START0, then START1 after the second transfer.
- Port 0 re-requesting continuously with REQ1 held -> port 1 is granted after exactly 4 port-0 grants (STARVE_MAX=4).
- DDS ACK stuck at 0, TIMEOUT=1023 -> REQ drops 1023 cycles after rising; ERR=1, ERR_ID=grant port; ACKx still asserted; the next successful transfer clears ERR.
- rst_n pulled low during WAIT_AH -> REQ, ACK0, ACK1 and all DDS_* read 0 asynchronously; after release a new REQ1 completes normally.
